// File: rtl/filter_luma_8tap_mac_if.sv
`default_nettype none
// ============================================================================
//  Module   : read_interface / write_interface
//  Purpose  : Multi-flux tagged FIFO read and write ports.
//  Revision : 1.0
// ============================================================================

interface read_interface #(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 10
);
    logic [FLUX-1:0]       empty;
    logic [FLUX-1:0]       read;
    logic [DATA_WIDTH-1:0] dout;

    modport actor  (input empty, input dout, output read);
    modport master (input empty, input dout, output read);
    modport slave  (output empty, output dout, input read);
endinterface

interface write_interface #(
    parameter int DATA_WIDTH = 17
);
    logic                  full;
    logic                  write;
    logic [DATA_WIDTH-1:0] din;

    modport actor  (input full, output write, output din);
    modport master (input full, output write, output din);
    modport slave  (output full, input write, input din);
endinterface

`default_nettype wire

// File: rtl/filter_luma_8tap_mac.sv
`default_nettype none
// ============================================================================
//  Module   : filter_luma_8tap_mac
//  Purpose  : Serial 8-tap luma interpolation MAC, one tap per cycle, tagged.
//  Revision : 1.0
// ============================================================================

module filter_luma_8tap_mac #(
    parameter int FLUX        = 2,
    parameter int CDATA_WIDTH = 9,
    parameter int XDATA_WIDTH = 8,
    parameter int YDATA_WIDTH = 16,
    parameter int ACC_WIDTH   = 18,
    parameter int TAG_WIDTH   = $clog2(FLUX)
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    read_interface.actor  read_port_c0,
    read_interface.actor  read_port_c1,
    read_interface.actor  read_port_c2,
    read_interface.actor  read_port_c3,
    read_interface.actor  read_port_c4,
    read_interface.actor  read_port_c5,
    read_interface.actor  read_port_c6,
    read_interface.actor  read_port_c7,
    read_interface.actor  read_port_x,
    write_interface.actor write_port_y
);
    localparam int NTAP = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [TAG_WIDTH-1:0]        tag_q, tag_d;
    logic [2:0]                  k_q, k_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CDATA_WIDTH-1:0]      coef_q [NTAP];
    logic [CDATA_WIDTH-1:0]      coef_d [NTAP];
    logic [YDATA_WIDTH-1:0]      y_q, y_d;

    logic [FLUX-1:0]             w_c_empty_any;
    logic [CDATA_WIDTH-1:0]      w_c_dout [NTAP];
    logic [FLUX-1:0]             w_c_read;
    logic [FLUX-1:0]             w_x_read;
    logic                        w_sel_valid;
    logic [TAG_WIDTH-1:0]        w_sel_tag;
    logic [CDATA_WIDTH-1:0]      w_coef_sel;
    logic signed [ACC_WIDTH-1:0] w_coef_ext;
    logic signed [ACC_WIDTH-1:0] w_x_ext;
    logic signed [ACC_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic                        w_unused_tags;

    // A flux is only eligible when all eight coefficient FIFOs hold an entry for it.
    assign w_c_empty_any = read_port_c0.empty | read_port_c1.empty | read_port_c2.empty
                         | read_port_c3.empty | read_port_c4.empty | read_port_c5.empty
                         | read_port_c6.empty | read_port_c7.empty;

    assign w_c_dout[0] = read_port_c0.dout[CDATA_WIDTH-1:0];
    assign w_c_dout[1] = read_port_c1.dout[CDATA_WIDTH-1:0];
    assign w_c_dout[2] = read_port_c2.dout[CDATA_WIDTH-1:0];
    assign w_c_dout[3] = read_port_c3.dout[CDATA_WIDTH-1:0];
    assign w_c_dout[4] = read_port_c4.dout[CDATA_WIDTH-1:0];
    assign w_c_dout[5] = read_port_c5.dout[CDATA_WIDTH-1:0];
    assign w_c_dout[6] = read_port_c6.dout[CDATA_WIDTH-1:0];
    assign w_c_dout[7] = read_port_c7.dout[CDATA_WIDTH-1:0];

    assign w_unused_tags = ^{read_port_c0.dout[TAG_WIDTH+CDATA_WIDTH-1:CDATA_WIDTH],
                             read_port_c1.dout[TAG_WIDTH+CDATA_WIDTH-1:CDATA_WIDTH],
                             read_port_c2.dout[TAG_WIDTH+CDATA_WIDTH-1:CDATA_WIDTH],
                             read_port_c3.dout[TAG_WIDTH+CDATA_WIDTH-1:CDATA_WIDTH],
                             read_port_c4.dout[TAG_WIDTH+CDATA_WIDTH-1:CDATA_WIDTH],
                             read_port_c5.dout[TAG_WIDTH+CDATA_WIDTH-1:CDATA_WIDTH],
                             read_port_c6.dout[TAG_WIDTH+CDATA_WIDTH-1:CDATA_WIDTH],
                             read_port_c7.dout[TAG_WIDTH+CDATA_WIDTH-1:CDATA_WIDTH],
                             read_port_x.dout[TAG_WIDTH+XDATA_WIDTH-1:XDATA_WIDTH]};

    assign read_port_c0.read = w_c_read;
    assign read_port_c1.read = w_c_read;
    assign read_port_c2.read = w_c_read;
    assign read_port_c3.read = w_c_read;
    assign read_port_c4.read = w_c_read;
    assign read_port_c5.read = w_c_read;
    assign read_port_c6.read = w_c_read;
    assign read_port_c7.read = w_c_read;
    assign read_port_x.read  = w_x_read;

    // Highest ready flux index wins.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_tag   = '0;
        for (int t = 0; t < FLUX; t++) begin
            if (!w_c_empty_any[t]) begin
                w_sel_valid = 1'b1;
                w_sel_tag   = TAG_WIDTH'(t);
            end
        end
    end

    assign w_coef_sel = coef_q[k_q];
    assign w_coef_ext = {{(ACC_WIDTH-CDATA_WIDTH){w_coef_sel[CDATA_WIDTH-1]}}, w_coef_sel};
    assign w_x_ext    = {{(ACC_WIDTH-XDATA_WIDTH){1'b0}}, read_port_x.dout[XDATA_WIDTH-1:0]};
    assign w_prod     = w_coef_ext * w_x_ext;
    assign w_sum      = acc_q + w_prod;

    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        k_d      = k_q;
        acc_d    = acc_q;
        coef_d   = coef_q;
        y_d      = y_q;
        w_c_read = '0;
        w_x_read = '0;
        case (state_q)
            S_IDLE: begin
                // Reads are combinational, so keep them quiet while reset is held.
                if (w_sel_valid && rst_n) begin
                    w_c_read[w_sel_tag] = 1'b1;
                    coef_d              = w_c_dout;
                    tag_d               = w_sel_tag;
                    k_d                 = 3'd0;
                    acc_d               = '0;
                    state_d             = S_MAC;
                end
            end
            S_MAC: begin
                if (!read_port_x.empty[tag_q]) begin
                    w_x_read[tag_q] = 1'b1;
                    acc_d           = w_sum;
                    if (k_q == 3'd7) begin
                        y_d     = w_sum[YDATA_WIDTH-1:0];
                        state_d = S_EMIT;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end
            S_EMIT: begin
                if (!write_port_y.full) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign write_port_y.write = (state_q == S_EMIT) && !write_port_y.full;
    assign write_port_y.din   = (state_q == S_EMIT) ? {tag_q, y_q} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            k_q     <= 3'd0;
            acc_q   <= '0;
            y_q     <= '0;
            for (int i = 0; i < NTAP; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            for (int i = 0; i < NTAP; i++) begin
                coef_q[i] <= coef_d[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/filter_luma_8tap_mac.md
Name: filter_luma_8tap_mac

Overview:
- Serial 8-tap luma interpolation filter stage. Sits directly downstream of the luma coefficient generator.
- Per output sample, it pops one coefficient set (c0..c7) and eight reference samples from one tagged data flux, and multiply-accumulates one tap per cycle.
- It emits one tagged 16-bit signed filtered value.
- All ports are multi-flux tagged FIFO interfaces, so several independent data fluxes share the datapath.

Parameters:
- FLUX, 2, number of multiplexed data fluxes. TAG_WIDTH = $clog2(FLUX).
- CDATA_WIDTH, 9, signed coefficient width (tag excluded).
- XDATA_WIDTH, 8, unsigned sample width (tag excluded).
- YDATA_WIDTH, 16, signed output width (tag excluded).
- ACC_WIDTH, 18, signed accumulator width.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- read_port_c0..read_port_c7  read_interface.actor  TAG_WIDTH+CDATA_WIDTH  coefficient FIFOs. Signals: empty[FLUX], read[FLUX], dout.
- read_port_x  read_interface.actor  TAG_WIDTH+XDATA_WIDTH  reference sample FIFO. Signals: empty[FLUX], read[FLUX], dout.
- write_port_y  write_interface.actor  TAG_WIDTH+YDATA_WIDTH  filtered output. Signals: full, write, din = {tag, y}.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; tag_r=0; k=0; acc=0; coefficient registers=0; y_r=0.
  - All read[*]=0, write=0, din=0.
  - A reset mid-operation discards the locked coefficients, any partial sum and any samples already popped. Nothing is replayed.
- IDLE:
  - Select the highest index t for which empty[t]==0 on all of c0..c7.
  - If such a t exists: assert read[t] on c0..c7 combinationally in this cycle, latch their data fields, tag_r<=t, k<=0, acc<=0, go to MAC.
  - If none exists: all reads stay 0 and the block remains in IDLE.
  - read[] bits for other fluxes are always 0.
- MAC (k = 0..7):
  - If read_port_x.empty[tag_r]==0: assert read_port_x.read[tag_r] and set acc <= acc + coef[k] * $signed({1'b0, x}).
    - Coefficient is signed; sample is zero-extended.
    - The first sample popped pairs with c0, the eighth with c7.
  - If read_port_x.empty[tag_r]==1: stall. No read, and acc and k hold.
  - Samples are never taken from another flux while locked.
  - When k==7 and a read occurs: y_r <= low YDATA_WIDTH bits of the final sum, go to EMIT. Otherwise k <= k+1.
- EMIT:
  - write = !full. din = {tag_r, y_r}.
  - If full==0, the write happens and the state returns to IDLE.
  - If full==1, write=0 and the block holds EMIT indefinitely.
- Timing:
  - Minimum 10 cycles per output: 1 IDLE + 8 MAC + 1 EMIT.
  - Latency from coefficient pop to write assertion is 9 cycles with no stalls.
  - No overlap between consecutive outputs.
- Arithmetic:
  - No rounding or shift; this is the first filter stage at 8-bit depth.
  - For legal coefficient sets, |sum| ≤ 112*255 = 28560, so truncation to 16 bits is lossless.
  - No saturation. An out-of-range sum wraps as two's complement.
- Tag fields in c*/x dout are ignored. Routing uses the flux index only.
- Simultaneous events:
  - A flux that becomes available in the same cycle as the selection competes normally.
  - A flux with a higher index that becomes available while the block is locked is served only on the next IDLE.
- Mismatched tags across c0..c7 cannot occur, because selection requires all eight non-empty on the same t.

Test Plan:
- Coefficient set for alpha=0 (0,0,0,64,0,0,0,0) on flux 0, samples 10..17 -> one write, din={0, 16'd832}, asserted exactly 9 cycles after the coefficient pop.
- Coefficient set for alpha=4 (-1,4,-11,40,40,-11,4,-1) on flux 1, samples 0,0,255,0,0,0,0,0 -> din={1, 16'hF50B} (-2805).
- Coefficient set for alpha=2 on flux 0, all samples 255, plus 3 empty cycles on x injected after the 4th sample -> din={0, 16320}. MAC lasts 11 cycles, and acc/k hold during the stalls.
- Coefficients available on flux 0 and flux 1 in the same cycle -> flux 1 is processed first and flux 0 next.
  - While flux 1 is locked, flux 0's x reads stay 0.
- full=1 held for 5 cycles in EMIT -> write stays 0 and din stays stable. Write pulses once when full drops, and IDLE follows.
- rst_n dropped during MAC at k=4 -> all outputs are 0 immediately (asynchronously).
  - After release, the next full coefficient set plus 8 samples produces the correct, uncontaminated result.
